pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the fetch stage.
- Holds the PC and selects the next PC from a fixed priority chain: reset, interrupt, memory restore, stall, branch, return, sequential.
- Adds interrupt latching with a saved PC (EPC), handler masking, a return-address stack (RAS) for call/ret, and a halt limit.
- Feeds instruction-memory address and the IF/ID pipeline register.

Parameters:
- PC_W, 32, PC and address width.
- RESET_PC, 32, PC value loaded by reset.
- INT_VEC, 0, PC loaded on interrupt acceptance.
- PC_LIMIT, 100, sequential increment stops when pc_out >= PC_LIMIT.
- RAS_DEPTH, 4, return-address stack entries (power of two, >= 2).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  hazard stall; hold PC.
- int_req  input  1  level interrupt request.
- mem_wsp  input  1  authoritative PC restore from memory (RET/RTI).
- mem_pc  input  PC_W  value restored by mem_wsp.
- branch_taken  input  1  redirect to branch_dst.
- branch_dst  input  PC_W  branch/call target.
- call  input  1  with branch_taken: push pc_out+1 onto RAS.
- ret  input  1  predicted return: pop RAS, jump to popped value.
- pc_out  output  PC_W  current PC.
- epc  output  PC_W  PC saved at interrupt acceptance.
- int_ack  output  1  one-cycle pulse on acceptance.
- in_handler  output  1  interrupt handler active (masked).
- halted  output  1  PC held at limit.
- ras_empty  output  1  RAS has no entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_underflow  output  1  sticky: ret seen with RAS empty.

Behaviour:
- Reset values (one edge with reset=1): pc_out=RESET_PC, epc=0, int_ack=0, int_pending=0, state RUN, halted=0, RAS count=0, ras_underflow=0. Reset beats every other input, including mid-handler and during stall.
- int_pending is set on any edge with int_req=1 while state=RUN. It is cleared on acceptance. A request arriving during a stall is therefore not lost.
- States:
  - RUN: normal operation.
  - HANDLER: interrupts masked; in_handler=1.
- Next-PC priority, evaluated on each non-reset edge:
  1. Accept interrupt: state=RUN, int_pending=1, stall=0, mem_wsp=0. Then epc<=pc_out, pc_out<=INT_VEC, int_ack<=1 for one cycle, state<=HANDLER.
  2. mem_wsp=1: pc_out<=mem_pc. Applies even during stall. If state=HANDLER, state<=RUN.
  3. stall=1: pc_out, RAS and halted unchanged.
  4. branch_taken=1: pc_out<=branch_dst. If call=1, also push pc_out+1.
  5. ret=1:
     - RAS not empty: pc_out<=top entry; pop.
     - RAS empty: ras_underflow<=1 and fall through to item 6.
  6. Sequential: if pc_out < PC_LIMIT, pc_out<=pc_out+1 and halted<=0; else hold pc_out and halted<=1.
- halted clears on any redirect (items 1, 2, 4, 5) that loads a value below PC_LIMIT.
- Arithmetic: all adds are modulo 2^PC_W, no carry out. The limit compare is unsigned.
- RAS:
  - Circular buffer with top pointer and count.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - Simultaneous call and ret is illegal upstream; call wins and ret is ignored.
  - Pop and push take effect in the same edge as the PC update.
- mem_wsp in HANDLER with int_req still high: the restore wins. State returns to RUN and the interrupt is re-latched, then accepted no earlier than the following edge.
- int_req while in HANDLER is ignored; it is not latched.
- Latency: every redirect is visible on pc_out the cycle after the edge that samples it; no bubbles are inserted internally.

Decomposition:
- Shared package pc_pkg holds:
  - state enum {RUN, HANDLER}.
  - Default constants RESET_PC_DEF=32, INT_VEC_DEF=0, PC_LIMIT_DEF=100.
  - Next-PC select encoding for debug visibility.
- One sub-module, ras_stack: parametrised circular LIFO on PC_W and RAS_DEPTH with push, pop, top, empty, full and overwrite-on-full.

Test Plan:
- Reset, then 3 idle cycles -> pc_out 32, 33, 34, 35; halted=0. Run to 100 -> pc_out holds 100, halted=1.
- pc_out=40, int_req=1 together with stall=1 for 2 cycles, then stall=0 -> no change during the stall; next edge gives pc_out=0, epc=40, int_ack pulse, in_handler=1. Then mem_wsp=1 with mem_pc=40 -> pc_out=40, in_handler=0.
- In HANDLER: int_req=1 and mem_wsp=1 with mem_pc=55 -> pc_out=55, state RUN. Next edge -> pc_out=0, epc=55.
- Depth 4: five calls to 70 from pcs 36, 37, ... -> ras_full=1. Five rets -> targets 41, 40, 39, 38; the fifth ret has RAS empty -> ras_underflow=1 and pc increments.
- stall=1 with branch_taken=1, branch_dst=80 -> pc_out unchanged. mem_wsp=1 with stall=1, mem_pc=12 -> pc_out=12.
- reset asserted while in HANDLER with 2 RAS entries -> pc_out=32, in_handler=0, ras_empty=1, ras_underflow=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared state, next-PC select encoding and default constants for the fetch-stage PC unit.
package pc_pkg;

    localparam int RESET_PC_DEF = 32;
    localparam int INT_VEC_DEF  = 0;
    localparam int PC_LIMIT_DEF = 100;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_INT,
        SEL_MEM,
        SEL_HOLD,
        SEL_BRANCH,
        SEL_RET,
        SEL_SEQ,
        SEL_LIMIT
    } pc_sel_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address LIFO; push on a full stack overwrites the oldest entry.
// Zero-latency top read; push/pop take effect on the next edge; never stalls.
module ras_stack
    import pc_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_dat,
    output logic [PC_W-1:0] top_dat,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W:0]   cnt_q;

    assign top_inc = top_q + PTR_W'(1);
    assign top_dat = mem[top_q];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PTR_W+1)'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            top_q <= top_inc;
            if (!full) begin
                cnt_q <= cnt_q + (PTR_W+1)'(1);
            end
        end else if (pop && !empty) begin
            top_q <= top_q - PTR_W'(1);
            cnt_q <= cnt_q - (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[top_inc] <= push_dat;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with interrupt entry/EPC, return-address stack and halt limit.
// Every redirect appears on pc_out one cycle after the sampling edge; stall holds the PC, but a memory restore overrides it.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
    parameter logic [PC_W-1:0] INT_VEC   = PC_W'(INT_VEC_DEF),
    parameter logic [PC_W-1:0] PC_LIMIT  = PC_W'(PC_LIMIT_DEF),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            int_req,
    input  logic            mem_wsp,
    input  logic [PC_W-1:0] mem_pc,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_dst,
    input  logic            call,
    input  logic            ret,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] epc,
    output logic            int_ack,
    output logic            in_handler,
    output logic            halted,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow
);

    pc_state_t       state_q, state_d;
    pc_sel_t         sel;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, ras_top, epc_q;
    logic            pend_q, pend_d, halted_q, halted_d, under_q, under_d;
    logic            ack_q, accept, ret_eff, ras_push, ras_pop;

    assign pc_inc  = pc_q + PC_W'(1);
    // A call on the same cycle as ret takes precedence, so ret is dropped.
    assign ret_eff = ret && !call;
    assign accept  = (state_q == RUN) && pend_q && !stall && !mem_wsp;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        halted_d = halted_q;
        under_d  = under_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        sel      = SEL_SEQ;

        if (reset)                          sel = SEL_RESET;
        else if (accept)                    sel = SEL_INT;
        else if (mem_wsp)                   sel = SEL_MEM;
        else if (stall)                     sel = SEL_HOLD;
        else if (branch_taken)              sel = SEL_BRANCH;
        else if (ret_eff && !ras_empty)     sel = SEL_RET;
        else if (pc_q < PC_LIMIT)           sel = SEL_SEQ;
        else                                sel = SEL_LIMIT;

        // A restore out of the handler re-opens the latch in the same edge.
        if (accept) begin
            pend_d = 1'b0;
        end else if (int_req && (state_q == RUN || mem_wsp)) begin
            pend_d = 1'b1;
        end

        if (ret_eff && ras_empty && (sel inside {SEL_SEQ, SEL_LIMIT})) begin
            under_d = 1'b1;
        end

        case (sel)
            SEL_INT: begin
                pc_d    = INT_VEC;
                state_d = HANDLER;
            end
            SEL_MEM: begin
                pc_d    = mem_pc;
                state_d = RUN;
            end
            SEL_BRANCH: begin
                pc_d     = branch_dst;
                ras_push = call;
            end
            SEL_RET: begin
                pc_d    = ras_top;
                ras_pop = 1'b1;
            end
            SEL_SEQ: begin
                pc_d     = pc_inc;
                halted_d = 1'b0;
            end
            SEL_LIMIT: halted_d = 1'b1;
            default: ;
        endcase

        if ((sel inside {SEL_INT, SEL_MEM, SEL_BRANCH, SEL_RET}) && (pc_d < PC_LIMIT)) begin
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            epc_q    <= '0;
            ack_q    <= 1'b0;
            pend_q   <= 1'b0;
            halted_q <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            halted_q <= halted_d;
            under_q  <= under_d;
            ack_q    <= (sel == SEL_INT);
            if (sel == SEL_INT) begin
                epc_q <= pc_q;
            end
        end
    end

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_dat (pc_inc),
        .top_dat  (ras_top),
        .empty    (ras_empty),
        .full     (ras_full)
    );

    assign pc_out        = pc_q;
    assign epc           = epc_q;
    assign int_ack       = ack_q;
    assign in_handler    = (state_q == HANDLER);
    assign halted        = halted_q;
    assign ras_underflow = under_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed vector table, hand-written RAS/reset sequences and a randomized run against a queue-based reference model.
module tb_pc_unit;

    localparam int          PC_W      = 32;
    localparam int          RAS_DEPTH = 4;
    localparam logic [31:0] RESET_PC  = 32;
    localparam logic [31:0] INT_VEC   = 0;
    localparam logic [31:0] PC_LIMIT  = 100;

    logic        clk = 1'b0;
    logic        reset, stall, int_req, mem_wsp, branch_taken, call, ret;
    logic [31:0] mem_pc, branch_dst;
    logic [31:0] pc_out, epc;
    logic        int_ack, in_handler, halted, ras_empty, ras_full, ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .PC_W      (PC_W),
        .RESET_PC  (RESET_PC),
        .INT_VEC   (INT_VEC),
        .PC_LIMIT  (PC_LIMIT),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .int_req       (int_req),
        .mem_wsp       (mem_wsp),
        .mem_pc        (mem_pc),
        .branch_taken  (branch_taken),
        .branch_dst    (branch_dst),
        .call          (call),
        .ret           (ret),
        .pc_out        (pc_out),
        .epc           (epc),
        .int_ack       (int_ack),
        .in_handler    (in_handler),
        .halted        (halted),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow)
    );

    // Reference model: architectural state with the RAS as a plain queue.
    logic [31:0] m_pc, m_epc;
    bit          m_ack, m_pend, m_hand, m_halt, m_under;
    logic [31:0] m_ras[$];

    task automatic model_step();
        bit          acc;
        bit          new_pend;
        logic [31:0] tgt;
        if (reset) begin
            m_pc = RESET_PC; m_epc = 0; m_ack = 0; m_pend = 0;
            m_hand = 0; m_halt = 0; m_under = 0; m_ras.delete();
            return;
        end
        acc      = !m_hand && m_pend && !stall && !mem_wsp;
        new_pend = m_pend;
        if (acc) new_pend = 0;
        else if (int_req && (!m_hand || mem_wsp)) new_pend = 1;
        m_ack = 0;
        if (acc) begin
            m_epc = m_pc; m_pc = INT_VEC; m_ack = 1; m_hand = 1;
            if (INT_VEC < PC_LIMIT) m_halt = 0;
        end else if (mem_wsp) begin
            m_pc = mem_pc; m_hand = 0;
            if (mem_pc < PC_LIMIT) m_halt = 0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (branch_taken) begin
            if (call) begin
                m_ras.push_back(m_pc + 1);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end
            m_pc = branch_dst;
            if (branch_dst < PC_LIMIT) m_halt = 0;
        end else if (ret && !call && m_ras.size() > 0) begin
            tgt  = m_ras.pop_back();
            m_pc = tgt;
            if (tgt < PC_LIMIT) m_halt = 0;
        end else begin
            if (ret && !call) m_under = 1;
            if (m_pc < PC_LIMIT) begin
                m_pc = m_pc + 1; m_halt = 0;
            end else begin
                m_halt = 1;
            end
        end
        m_pend = new_pend;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic rs, input logic st, input logic ir, input logic ws,
                        input logic [31:0] mp, input logic bt, input logic [31:0] bd,
                        input logic cl, input logic rt);
        reset = rs; stall = st; int_req = ir; mem_wsp = ws; mem_pc = mp;
        branch_taken = bt; branch_dst = bd; call = cl; ret = rt;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " pc_out"},        pc_out,        m_pc);
        chk({tag, " epc"},           epc,           m_epc);
        chk({tag, " int_ack"},       int_ack,       m_ack);
        chk({tag, " in_handler"},    in_handler,    m_hand);
        chk({tag, " halted"},        halted,        m_halt);
        chk({tag, " ras_empty"},     ras_empty,     m_ras.size() == 0);
        chk({tag, " ras_full"},      ras_full,      m_ras.size() == RAS_DEPTH);
        chk({tag, " ras_underflow"}, ras_underflow, m_under);
    endtask

    task automatic random_cycle();
        logic        rs, st, ir, ws, bt, cl, rt;
        logic [31:0] mp, bd;
        rs = ($urandom_range(0, 199) == 0);
        st = ($urandom_range(0, 99) < 20);
        ir = ($urandom_range(0, 99) < 10);
        ws = ($urandom_range(0, 99) < 6);
        bt = ($urandom_range(0, 99) < 15);
        cl = ($urandom_range(0, 99) < 50);
        rt = ($urandom_range(0, 99) < 20);
        mp = $urandom_range(0, 120);
        bd = ($urandom_range(0, 1) == 1) ? $urandom_range(85, 120) : $urandom_range(0, 84);
        step(rs, st, ir, ws, mp, bt, bd, cl, rt);
        check_model("rand");
    endtask

    typedef struct {
        logic        rs, st, ir, ws;
        logic [31:0] mp;
        logic        bt;
        logic [31:0] bd;
        logic        cl, rt;
        logic [31:0] e_pc, e_epc;
        logic        e_ack, e_hand, e_halt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic rs, input logic st, input logic ir, input logic ws,
                               input logic [31:0] mp, input logic bt, input logic [31:0] bd,
                               input logic [31:0] e_pc, input logic [31:0] e_epc,
                               input logic e_ack, input logic e_hand, input logic e_halt);
        vec_t r;
        r.rs = rs; r.st = st; r.ir = ir; r.ws = ws; r.mp = mp; r.bt = bt; r.bd = bd;
        r.cl = 1'b0; r.rt = 1'b0;
        r.e_pc = e_pc; r.e_epc = e_epc; r.e_ack = e_ack; r.e_hand = e_hand; r.e_halt = e_halt;
        return r;
    endfunction

    int exp_ret[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; stall = 0; int_req = 0; mem_wsp = 0; mem_pc = 0;
        branch_taken = 0; branch_dst = 0; call = 0; ret = 0;

        //              rs st ir ws  mp  bt bd   pc  epc ack hnd hlt
        vq.push_back(v(1, 0, 0, 0,  0, 0, 0,   32,  0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,   33,  0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,   34,  0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,   35,  0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 1, 40, 0, 0,   40,  0, 0, 0, 0));
        vq.push_back(v(0, 1, 1, 0,  0, 0, 0,   40,  0, 0, 0, 0));
        vq.push_back(v(0, 1, 1, 0,  0, 0, 0,   40,  0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,    0, 40, 1, 1, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,    1, 40, 0, 1, 0));
        vq.push_back(v(0, 0, 0, 1, 40, 0, 0,   40, 40, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,   41, 40, 0, 0, 0));
        vq.push_back(v(0, 0, 1, 0,  0, 0, 0,   42, 40, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,    0, 42, 1, 1, 0));
        vq.push_back(v(0, 0, 1, 1, 55, 0, 0,   55, 42, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,    0, 55, 1, 1, 0));
        vq.push_back(v(0, 0, 0, 1, 97, 0, 0,   97, 55, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,   98, 55, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,   99, 55, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,  100, 55, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,  100, 55, 0, 0, 1));
        vq.push_back(v(0, 0, 0, 0,  0, 0, 0,  100, 55, 0, 0, 1));
        vq.push_back(v(0, 0, 0, 0,  0, 1, 50,  50, 55, 0, 0, 0));
        vq.push_back(v(0, 1, 0, 0,  0, 1, 80,  50, 55, 0, 0, 0));
        vq.push_back(v(0, 1, 0, 1, 12, 0, 0,   12, 55, 0, 0, 0));

        foreach (vq[i]) begin
            step(vq[i].rs, vq[i].st, vq[i].ir, vq[i].ws, vq[i].mp, vq[i].bt, vq[i].bd, vq[i].cl, vq[i].rt);
            chk($sformatf("vec%0d pc_out", i),     pc_out,     vq[i].e_pc);
            chk($sformatf("vec%0d epc", i),        epc,        vq[i].e_epc);
            chk($sformatf("vec%0d int_ack", i),    int_ack,    vq[i].e_ack);
            chk($sformatf("vec%0d in_handler", i), in_handler, vq[i].e_hand);
            chk($sformatf("vec%0d halted", i),     halted,     vq[i].e_halt);
        end

        // Five calls overflow a depth-4 stack; the fifth ret underflows.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ras reset empty", ras_empty, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 1, 36 + k, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 1, 70, 1, 0);
            chk($sformatf("call%0d pc_out", k), pc_out, 70);
        end
        chk("ras full after 5 calls", ras_full, 1);
        exp_ret = '{41, 40, 39, 38};
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1);
            chk($sformatf("ret%0d pc_out", k), pc_out, exp_ret[k]);
            chk($sformatf("ret%0d underflow", k), ras_underflow, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("ret4 pc_out", pc_out, 39);
        chk("ret4 underflow", ras_underflow, 1);
        chk("ret4 empty", ras_empty, 1);

        // Reset in the handler with live RAS entries and a sticky underflow.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("pre underflow", ras_underflow, 1);
        step(0, 0, 0, 0, 0, 1, 60, 1, 0);
        step(0, 0, 0, 0, 0, 1, 61, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle();
        chk("pre in_handler", in_handler, 1);
        chk("pre ras_empty", ras_empty, 0);
        chk("pre epc", epc, 62);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("rst pc_out", pc_out, 32);
        chk("rst in_handler", in_handler, 0);
        chk("rst ras_empty", ras_empty, 1);
        chk("rst ras_underflow", ras_underflow, 0);
        chk("rst epc", epc, 0);
        chk("rst halted", halted, 0);
        chk("rst int_ack", int_ack, 0);

        // Randomized run against the model.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_model("rand reset");
        for (int c = 0; c < 2000; c++) begin
            random_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
